inst_fetch_unit: RTL and testbench

//   Fetch-side initiator for the instruction memory: drives a byte PC onto the memory's

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch_unit.sv | 59 +++++
 tb/tb_inst_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction memory port and decode handshake of the fetch unit.
// master = fetch unit, slave = memory/decode/branch side.
interface inst_fetch_if #(
   parameter int FIFO_DEPTH = 4
);
   logic [31:0]                  imem_addr;
   logic [31:0]                  imem_data;
   logic                         imem_en;
   logic                         redirect;
   logic [31:0]                  redirect_pc;
   logic                         inst_valid;
   logic                         inst_ready;
   logic [31:0]                  inst;
   logic [31:0]                  inst_pc;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic                         misalign;
   modport master (
      output imem_addr, imem_en, inst_valid, inst, inst_pc, fifo_count, misalign,
      input  imem_data, redirect, redirect_pc, inst_ready
   );
   modport slave (
      input  imem_addr, imem_en, inst_valid, inst, inst_pc, fifo_count, misalign,
      output imem_data, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetch into a prefetch FIFO with redirect flush.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   inst_fetch_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   r_pc;
   logic [31:0]   r_inst [FIFO_DEPTH];
   logic [31:0]   r_ipc  [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_misalign;
   logic          w_valid;
   logic          w_pop;
   logic          w_en;
   assign w_valid = r_count != '0;
   assign w_pop   = w_valid & bus.inst_ready;
   // a full FIFO may still fetch when the head leaves on the same edge
   assign w_en    = !bus.redirect & ((r_count != CW'(FIFO_DEPTH)) | w_pop);
   assign bus.imem_addr  = r_pc;
   assign bus.imem_en    = w_en;
   assign bus.inst_valid = w_valid;
   assign bus.inst       = w_valid ? r_inst[r_rptr] : '0;
   assign bus.inst_pc    = w_valid ? r_ipc[r_rptr] : '0;
   assign bus.fifo_count = r_count;
   assign bus.misalign   = r_misalign;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
      end else if (bus.redirect) begin
         r_pc       <= {bus.redirect_pc[31:2], 2'b00};
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_misalign <= r_misalign | (bus.redirect_pc[1:0] != 2'b00);
      end else begin
         r_pc    <= w_en ? r_pc + 32'd4 : r_pc;
         r_wptr  <= w_en ? r_wptr + AW'(1) : r_wptr;
         r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
         r_count <= r_count + CW'(w_en) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n && w_en) begin
         r_inst[r_wptr] <= bus.imem_data;
         r_ipc[r_wptr]  <= r_pc;
      end
   end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed vectors plus a queue-based fetch model checked every cycle.
module tb_inst_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   inst_fetch_if #(.FIFO_DEPTH(4)) bus_a ();
   inst_fetch_if #(.FIFO_DEPTH(4)) bus_b ();
   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0020_0093;
         32'h4:   return 32'h0030_0113;
         32'h8:   return 32'h0111_0193;
         default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
      endcase
   endfunction
   assign bus_a.imem_data   = mem_word(bus_a.imem_addr);
   assign bus_b.imem_data   = mem_word(bus_b.imem_addr);
   assign bus_b.inst_ready  = 1'b1;
   assign bus_b.redirect    = 1'b0;
   assign bus_b.redirect_pc = 32'h0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   // model: a queue of {pc, word} entries in fetch order
   logic [63:0] q[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_pop;
   logic        m_en;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_pc  = 32'h0;
         m_mis = 1'b0;
      end else if (bus_a.redirect) begin
         q.delete();
         m_pc = bus_a.redirect_pc & 32'hFFFF_FFFC;
         if (bus_a.redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
         m_pop = q.size() > 0 && bus_a.inst_ready;
         m_en  = q.size() < 4 || m_pop;
         if (m_pop) void'(q.pop_front());
         if (m_en) begin
            q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   end
   always @(negedge clk) begin
      logic [63:0] head;
      head = q.size() > 0 ? q[0] : 64'h0;
      chk("valid", 32'(bus_a.inst_valid), 32'(q.size() > 0));
      chk("inst", bus_a.inst, head[31:0]);
      chk("inst_pc", bus_a.inst_pc, head[63:32]);
      chk("count", 32'(bus_a.fifo_count), 32'(q.size()));
      chk("imem_addr", bus_a.imem_addr, m_pc);
      chk("imem_en", 32'(bus_a.imem_en),
          32'(!bus_a.redirect && (q.size() < 4 || (q.size() > 0 && bus_a.inst_ready))));
      chk("misalign", 32'(bus_a.misalign), 32'(m_mis));
   end
   initial begin
      bus_a.inst_ready  = 1'b0;
      bus_a.redirect    = 1'b0;
      bus_a.redirect_pc = 32'h0;
      #2 rst_n = 1'b0;
      tick();
      chk("rst_valid", 32'(bus_a.inst_valid), 32'h0);
      chk("rst_inst", bus_a.inst, 32'h0);
      chk("rst_count", 32'(bus_a.fifo_count), 32'h0);
      chk("rst_addr_b", bus_b.imem_addr, 32'hFFFF_FFF8);
      // sequential fetch, both the zero and wrap-around reset PCs
      rst_n = 1'b1;
      bus_a.inst_ready = 1'b1;
      tick();
      chk("t1_inst0", bus_a.inst, 32'h0020_0093);
      chk("t1_pc0", bus_a.inst_pc, 32'h0);
      chk("t5_pc0", bus_b.inst_pc, 32'hFFFF_FFF8);
      tick();
      chk("t1_inst1", bus_a.inst, 32'h0030_0113);
      chk("t1_pc1", bus_a.inst_pc, 32'h4);
      chk("t5_pc1", bus_b.inst_pc, 32'hFFFF_FFFC);
      tick();
      chk("t1_inst2", bus_a.inst, 32'h0111_0193);
      chk("t1_pc2", bus_a.inst_pc, 32'h8);
      chk("t5_pc2", bus_b.inst_pc, 32'h0);
      // backpressure then drain
      rst_n = 1'b0;
      bus_a.inst_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t2_count", 32'(bus_a.fifo_count), 32'(i));
      end
      chk("t2_en_full", 32'(bus_a.imem_en), 32'h0);
      tick();
      chk("t2_hold_addr", bus_a.imem_addr, 32'h10);
      chk("t2_hold_count", 32'(bus_a.fifo_count), 32'h4);
      bus_a.inst_ready = 1'b1;
      #1;
      chk("t2_en_pop", 32'(bus_a.imem_en), 32'h1);
      chk("t2_head", bus_a.inst_pc, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t2_drain_pc", bus_a.inst_pc, 32'(4 * i));
         chk("t2_drain_cnt", 32'(bus_a.fifo_count), 32'h4);
      end
      // redirect flush with three entries queued
      rst_n = 1'b0;
      bus_a.inst_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t3_count3", 32'(bus_a.fifo_count), 32'h3);
      bus_a.redirect = 1'b1;
      bus_a.redirect_pc = 32'h8;
      tick();
      chk("t3_valid", 32'(bus_a.inst_valid), 32'h0);
      chk("t3_count", 32'(bus_a.fifo_count), 32'h0);
      bus_a.redirect = 1'b0;
      tick();
      chk("t3_inst", bus_a.inst, 32'h0111_0193);
      chk("t3_pc", bus_a.inst_pc, 32'h8);
      // misaligned target, sticky flag, back-to-back redirects
      bus_a.redirect = 1'b1;
      bus_a.redirect_pc = 32'h6;
      tick();
      chk("t4_addr", bus_a.imem_addr, 32'h4);
      chk("t4_mis", 32'(bus_a.misalign), 32'h1);
      bus_a.redirect_pc = 32'h20;
      tick();
      chk("t4_mis_keep", 32'(bus_a.misalign), 32'h1);
      bus_a.redirect_pc = 32'h40;
      tick();
      bus_a.redirect_pc = 32'h80;
      tick();
      chk("t4_last_wins", bus_a.imem_addr, 32'h80);
      chk("t4_empty", 32'(bus_a.fifo_count), 32'h0);
      bus_a.redirect = 1'b0;
      tick();
      chk("t4_pc80", bus_a.inst_pc, 32'h80);
      rst_n = 1'b0;
      #1;
      chk("t4_mis_clr", 32'(bus_a.misalign), 32'h0);
      tick();
      rst_n = 1'b1;
      // asynchronous reset of a full FIFO between edges
      repeat (5) tick();
      chk("t6_full", 32'(bus_a.fifo_count), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(bus_a.inst_valid), 32'h0);
      chk("t6_count", 32'(bus_a.fifo_count), 32'h0);
      chk("t6_addr", bus_a.imem_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      bus_a.inst_ready = 1'b1;
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
